// File: rtl/wave_chan_mux.sv
// wave_chan_mux
//   Channel multiplexer and phase stepper for the QSPI waveform generator.
//   A single phase accumulator addresses NCH waveform ROMs in parallel. The
//   active channel gets a one-hot read enable. The returned sample is scaled
//   by a power-of-two gain and registered toward the DAC. Control words that
//   arrive while running are held in a shadow copy. They take effect only when
//   the phase wraps, so a period is never cut mid-way.
//
//   Optional build macro: WAVE_MUX_SAT_EN
//     defined   : left-shift gain saturates to all-ones on overflow
//     undefined : left-shift gain truncates to DW bits
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   ctrl_valid            strobe qualifying ctrl_sel / ctrl_gain / ctrl_freq
//   ctrl_sel   [SW]       requested channel (values >= NCH leave sel unchanged)
//   ctrl_gain  [3]        [2]=0 shift right by [1:0], [2]=1 shift left by [1:0]
//   ctrl_freq  [3]        phase step = 1 << ctrl_freq
//   run                   advance phase and read the ROMs
//   rd_addr    [AW]       shared ROM address
//   rd_en      [NCH]      one-hot ROM enable for the active channel
//   rd_data    [NCH*DW]   ROM outputs, channel k at [k*DW +: DW], 1-cycle latency
//   data_out   [DW]       scaled sample
//   data_valid            data_out refreshed this cycle
//   pending               shadowed word waiting for the next wrap
module wave_chan_mux #(
  parameter  int NCH = 4,
  parameter  int DW  = 12,
  parameter  int AW  = 9,
  localparam int SW  = $clog2(NCH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ctrl_valid,
  input  logic [SW-1:0]       ctrl_sel,
  input  logic [2:0]          ctrl_gain,
  input  logic [2:0]          ctrl_freq,
  input  logic                run,
  output logic [AW-1:0]       rd_addr,
  output logic [NCH-1:0]      rd_en,
  input  logic [NCH*DW-1:0]   rd_data,
  output logic [DW-1:0]       data_out,
  output logic                data_valid,
  output logic                pending
);

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [2:0]    gain;
    logic [2:0]    freq;
  } ctrl_t;

  localparam logic [SW:0] NCH_W = (SW+1)'(NCH);

  ctrl_t                 act_q, sh_q, word_direct, word_shadow;
  logic                  pend_q;
  logic [AW-1:0]         addr_q;
  logic [AW:0]           step, sum;
  logic                  wrap, sel_ok;

  // vld_pipe[0] is the read issued this cycle; vld_pipe[2] is data_valid.
  logic [2:0]            vld_pipe;
  logic [SW-1:0]         s1_sel;
  logic [2:0]            s1_gain;
  logic [NCH-1:0][DW-1:0] rom_w;
  logic [DW-1:0]         smp, scaled;

  assign rom_w = rd_data;

  // Phase step and wrap detection. The carry out of the AW+1 bit sum marks
  // the cycle on which the period ends.
  always_comb begin
    step   = {{AW{1'b0}}, 1'b1} << act_q.freq;
    sum    = {1'b0, addr_q} + step;
    wrap   = run & sum[AW];
    sel_ok = {1'b0, ctrl_sel} < NCH_W;
    // An out-of-range sel keeps whichever sel would otherwise apply next.
    word_direct = '{sel: sel_ok ? ctrl_sel : act_q.sel,
                    gain: ctrl_gain, freq: ctrl_freq};
    word_shadow = '{sel: sel_ok ? ctrl_sel : (pend_q ? sh_q.sel : act_q.sel),
                    gain: ctrl_gain, freq: ctrl_freq};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      act_q  <= '0;
      sh_q   <= '0;
      pend_q <= 1'b0;
    end else begin
      if (run) addr_q <= sum[AW-1:0];
      // The wrap swaps in the old shadow. A coincident write lands in the
      // shadow afterwards and stays pending until the next wrap.
      if (wrap && pend_q) act_q <= sh_q;
      if (ctrl_valid && run) begin
        sh_q   <= word_shadow;
        pend_q <= 1'b1;
      end else if (ctrl_valid) begin
        act_q  <= word_direct;
        pend_q <= 1'b0;
      end else if (wrap) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign rd_addr  = addr_q;
  assign rd_en    = (run && rst_n) ? (NCH'(1) << act_q.sel) : '0;
  assign pending  = pend_q;
  assign vld_pipe[0] = run & rst_n;

  // Stage 1 carries sel and gain alongside the ROM access. This keeps a
  // channel or gain switch aligned with the first sample read after the wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe[2:1] <= '0;
      s1_sel        <= '0;
      s1_gain       <= '0;
      data_out      <= '0;
    end else begin
      vld_pipe[2:1] <= vld_pipe[1:0];
      s1_sel        <= act_q.sel;
      s1_gain       <= act_q.gain;
      if (vld_pipe[1]) data_out <= scaled;
    end
  end

  assign smp = rom_w[s1_sel];

`ifdef WAVE_MUX_SAT_EN
  logic [DW+2:0] wide;
  always_comb begin
    wide = {3'b000, smp} << s1_gain[1:0];
    if (!s1_gain[2])        scaled = smp >> s1_gain[1:0];
    else if (|wide[DW+2:DW]) scaled = '1;
    else                    scaled = wide[DW-1:0];
  end
`else
  always_comb begin
    if (!s1_gain[2]) scaled = smp >> s1_gain[1:0];
    else             scaled = smp << s1_gain[1:0];
  end
`endif

  assign data_valid = vld_pipe[2];

endmodule

// File: tb/tb_wave_chan_mux.sv
module tb_wave_chan_mux;
  localparam int NCH = 5;
  localparam int DW  = 12;
  localparam int AW  = 9;
  localparam int SW  = $clog2(NCH);

  logic clk = 0;
  logic rst_n, ctrl_valid, run;
  logic [SW-1:0] ctrl_sel;
  logic [2:0] ctrl_gain, ctrl_freq;
  logic [AW-1:0] rd_addr;
  logic [NCH-1:0] rd_en;
  logic [NCH*DW-1:0] rd_data;
  logic [DW-1:0] data_out;
  logic data_valid, pending;

  always #5 clk = ~clk;

  wave_chan_mux #(.NCH(NCH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_valid(ctrl_valid), .ctrl_sel(ctrl_sel),
    .ctrl_gain(ctrl_gain), .ctrl_freq(ctrl_freq), .run(run),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .data_out(data_out), .data_valid(data_valid), .pending(pending));

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;
  bit rom_mode = 0;
  int rom_const = 0;

  // ROMs: channel k holds addr + k*100, or a fixed word in constant mode.
  function automatic int rom_val(int k, int a);
    if (rom_mode) return rom_const;
    return (a + k * 100) % 4096;
  endfunction

  logic [NCH-1:0][DW-1:0] rom_q = '0;
  assign rd_data = rom_q;
  always @(posedge clk)
    for (int k = 0; k < NCH; k++)
      if (rd_en[k]) rom_q[k] <= DW'(rom_val(k, int'(rd_addr)));

  function automatic int scale(int x, int g);
    int v;
    if (g < 4) return x >> g;
    v = x << (g - 4);
`ifdef WAVE_MUX_SAT_EN
    if (v > 4095) return 4095;
`endif
    return v % 4096;
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase as an integer, control words as plain fields,
  // samples as a two-deep delay of "what the selected ROM returns, scaled".
  int m_addr, m_asel, m_again, m_afreq, m_ssel, m_sgain, m_sfreq, m_pend;
  int m_p1v, m_p1d, m_dv, m_do;

  function automatic bit m_wrap();
    return run && (m_addr + (1 << m_afreq)) >= 512;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_addr <= 0; m_asel <= 0; m_again <= 0; m_afreq <= 0;
      m_ssel <= 0; m_sgain <= 0; m_sfreq <= 0; m_pend <= 0;
      m_p1v <= 0; m_p1d <= 0; m_dv <= 0; m_do <= 0;
    end else begin
      if (run) m_addr <= (m_addr + (1 << m_afreq)) % 512;
      if (m_wrap() && m_pend != 0) begin
        m_asel <= m_ssel; m_again <= m_sgain; m_afreq <= m_sfreq;
      end
      if (ctrl_valid && run) begin
        m_ssel  <= (ctrl_sel < NCH) ? int'(ctrl_sel) : (m_pend != 0 ? m_ssel : m_asel);
        m_sgain <= ctrl_gain; m_sfreq <= ctrl_freq; m_pend <= 1;
      end else if (ctrl_valid) begin
        m_asel  <= (ctrl_sel < NCH) ? int'(ctrl_sel) : m_asel;
        m_again <= ctrl_gain; m_afreq <= ctrl_freq; m_pend <= 0;
      end else if (m_wrap()) begin
        m_pend <= 0;
      end
      m_p1v <= run;
      m_p1d <= scale(rom_val(m_asel, m_addr), m_again);
      m_dv  <= m_p1v;
      if (m_p1v != 0) m_do <= m_p1d;
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("m_addr",  int'(rd_addr),    m_addr);
    chk("m_rd_en", int'(rd_en),      (run && rst_n) ? (1 << m_asel) : 0);
    chk("m_pend",  int'(pending),    m_pend);
    chk("m_dv",    int'(data_valid), m_dv);
    chk("m_dout",  int'(data_out),   m_do);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_addr(int a);
    int n = 0;
    while (int'(rd_addr) != a && n < 200) begin tick(); n++; end
    chk("wait_addr", int'(rd_addr), a);
  endtask

  task automatic wr(int s, int g, int f);
    ctrl_valid = 1; ctrl_sel = SW'(s); ctrl_gain = 3'(g); ctrl_freq = 3'(f);
    tick();
    ctrl_valid = 0;
  endtask

  int a0;
  int gl[6] = '{0, 1, 3, 4, 6, 7};

  initial begin
    rst_n = 0; run = 0; ctrl_valid = 0; ctrl_sel = 0; ctrl_gain = 0; ctrl_freq = 0;
    tick(); tick();
    chk_en = 1;
    chk("rst_addr", int'(rd_addr), 0);
    chk("rst_en", int'(rd_en), 0);
    chk("rst_dout", int'(data_out), 0);
    chk("rst_dv", int'(data_valid), 0);
    chk("rst_pend", int'(pending), 0);

    // Ramp: step 1, channel 0.
    rst_n = 1; run = 1;
    tick(); tick();
    chk("ramp_addr", int'(rd_addr), 2);
    chk("ramp_en", int'(rd_en), 5'b00001);
    chk("ramp_dv", int'(data_valid), 1);
    chk("ramp_d0", int'(data_out), 0);
    tick(); chk("ramp_d1", int'(data_out), 1);
    tick(); chk("ramp_d2", int'(data_out), 2);
    repeat (4) tick();
    run = 0; repeat (3) tick();

    // Shadowed channel switch at the 504 -> 0 wrap.
    rst_n = 0; tick(); rst_n = 1;
    wr(0, 0, 3);
    chk("direct_pend", int'(pending), 0);
    run = 1;
    wait_addr(40);
    wr(2, 0, 3);
    chk("sh_pend", int'(pending), 1);
    chk("sh_en_old", int'(rd_en), 5'b00001);
    wait_addr(504);
    tick();
    chk("wrap_addr", int'(rd_addr), 0);
    chk("wrap_en", int'(rd_en), 5'b00100);
    chk("wrap_pend", int'(pending), 0);
    tick(); chk("wrap_last_ch0", int'(data_out), 504);
    tick(); chk("wrap_first_ch2", int'(data_out), 200);

    // Write coinciding with a pending wrap: A applies, B waits.
    wr(1, 0, 3);
    wait_addr(504);
    wr(3, 0, 3);
    chk("coinc_en", int'(rd_en), 5'b00010);
    chk("coinc_pend", int'(pending), 1);
    wait_addr(504);
    tick();
    chk("coinc2_en", int'(rd_en), 5'b01000);
    chk("coinc2_pend", int'(pending), 0);

    // Gain.
    run = 0; repeat (3) tick();
    rom_mode = 1; rom_const = 12'hFFC;
    wr(0, 3'b010, 0);
    run = 1; tick(); tick();
    chk("gain_r2", int'(data_out), 12'h3FF);
    run = 0; repeat (3) tick();
    rom_const = 12'h900;
    wr(0, 3'b101, 0);
    run = 1; tick(); tick();
`ifdef WAVE_MUX_SAT_EN
    chk("gain_l1", int'(data_out), 12'hFFF);
`else
    chk("gain_l1", int'(data_out), 12'h200);
`endif
    rom_const = 12'h9A5;
    foreach (gl[i]) begin
      run = 0; repeat (3) tick();
      wr(0, gl[i], 0);
      run = 1; repeat (4) tick();
    end

    // Direct load while stopped; out-of-range sel keeps the old channel.
    run = 0; rom_mode = 0; repeat (3) tick();
    wr(1, 0, 1);
    chk("dir_pend", int'(pending), 0);
    run = 1; tick();
    chk("dir_en", int'(rd_en), 5'b00010);
    a0 = int'(rd_addr); tick();
    chk("dir_step2", int'(rd_addr), (a0 + 2) % 512);
    run = 0; tick();
    wr(7, 0, 2);
    wr(5, 0, 2);
    run = 1; tick();
    chk("oor_en", int'(rd_en), 5'b00010);
    a0 = int'(rd_addr); tick();
    chk("oor_step4", int'(rd_addr), (a0 + 4) % 512);

    // Reset mid-run with a pending word.
    wr(3, 1, 5);
    chk("pre_rst_pend", int'(pending), 1);
    rst_n = 0; tick();
    chk("mrst_addr", int'(rd_addr), 0);
    chk("mrst_en", int'(rd_en), 0);
    chk("mrst_dout", int'(data_out), 0);
    chk("mrst_dv", int'(data_valid), 0);
    chk("mrst_pend", int'(pending), 0);
    rst_n = 1; tick();
    chk("post_rst_step1", int'(rd_addr), 1);
    chk("post_rst_en", int'(rd_en), 5'b00001);
    run = 0; repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
